// File: rtl/bs_queue_pkg.sv
// Shared sizing helpers and entry field layout for the bank-scheduler queues.
// Used by the classifier, the queues and the scheduler.
package bs_queue_pkg;

  localparam int unsigned ROW_POS_DEF    = 32'd16;
  localparam int unsigned ROW_BITS_DEF   = 32'd4;
  localparam int unsigned BURST_POS_DEF  = 32'd20;
  localparam int unsigned BURST_BITS_DEF = 32'd3;

  // Channel index width; at least one bit so a port always exists.
  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch > 32'd1) ? $clog2(num_ch) : 32'd1;
  endfunction

  // Occupancy width: one extra bit so a full queue (count == DEPTH) is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 32'd1;
  endfunction

endpackage

// File: rtl/bs_multi_queue_if.sv
// Shared write/read port bundle of the multi-channel bank queue.
// The producer/consumer side uses master; the queue uses slave.
interface bs_multi_queue_if #(
  parameter int unsigned NUM_CH     = 32'd4,
  parameter int unsigned ENTRY_SIZE = 32'd32
);
  import bs_queue_pkg::*;

  localparam int unsigned CH_W = ch_w(NUM_CH);

  logic                  wr_en;
  logic [CH_W-1:0]       wr_ch;
  logic [ENTRY_SIZE-1:0] wr_data;
  logic                  rd_en;
  logic [CH_W-1:0]       rd_ch;
  logic [ENTRY_SIZE-1:0] rd_data;

  modport master (output wr_en, wr_ch, wr_data, rd_en, rd_ch, input rd_data);
  modport slave  (input wr_en, wr_ch, wr_data, rd_en, rd_ch, output rd_data);

endinterface

// File: rtl/bs_queue_ch.sv
// Single circular queue channel: accept/flush/count logic plus show-ahead head
// and tail field extraction. Storage is not cleared on read.
module bs_queue_ch
  import bs_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = 32'd4,
  parameter int unsigned ENTRY_SIZE = 32'd32,
  parameter int unsigned ROW_POS    = ROW_POS_DEF,
  parameter int unsigned ROW_BITS   = ROW_BITS_DEF,
  parameter int unsigned BURST_POS  = BURST_POS_DEF,
  parameter int unsigned BURST_BITS = BURST_BITS_DEF,
  parameter int unsigned AFULL_TH   = 32'd3,
  localparam int unsigned CNT_W     = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_req,
  input  logic [ENTRY_SIZE-1:0] wr_data,
  input  logic                  rd_req,
  output logic [ENTRY_SIZE-1:0] head_data,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  afull,
  output logic [ROW_BITS-1:0]   head_row,
  output logic [BURST_BITS-1:0] tail_burst,
  output logic                  wr_drop,
  output logic                  rd_drop
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

  logic [ENTRY_SIZE-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      tail_ptr_s;
  logic [CNT_W-1:0]      count_r;
  logic                  empty_s;
  logic                  rd_ok_s;
  logic                  wr_ok_s;

  assign empty_s = (count_r == {CNT_W{1'b0}});
  // A full channel still takes a write when the same cycle pops it.
  assign rd_ok_s = rd_req && !flush && !empty_s;
  assign wr_ok_s = wr_req && !flush && ((count_r != DEPTH_C) || rd_ok_s);
  assign wr_drop = wr_req && !flush && !wr_ok_s;
  assign rd_drop = rd_req && !flush && empty_s;

  // Pointer, occupancy and storage update; flush discards contents by pointer reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {ENTRY_SIZE{1'b0}};
      end
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign tail_ptr_s = wr_ptr_r - PTR_ONE;
  assign head_data  = empty_s ? {ENTRY_SIZE{1'b0}} : mem_r[rd_ptr_r];
  assign head_row   = head_data[ROW_POS +: ROW_BITS];
  assign tail_burst = empty_s ? {BURST_BITS{1'b0}} : mem_r[tail_ptr_s][BURST_POS +: BURST_BITS];
  assign count      = count_r;
  assign empty      = empty_s;
  assign full       = (count_r == DEPTH_C);
  assign afull      = (count_r >= AFULL_C);

endmodule

// File: rtl/bs_multi_queue.sv
// NUM_CH independent bank queues behind one write port and one read port.
// Decodes channel selects, muxes the show-ahead read data and owns sticky errors.
module bs_multi_queue
  import bs_queue_pkg::*;
#(
  parameter int unsigned NUM_CH     = 32'd4,
  parameter int unsigned DEPTH      = 32'd4,
  parameter int unsigned ENTRY_SIZE = 32'd32,
  parameter int unsigned ROW_POS    = ROW_POS_DEF,
  parameter int unsigned ROW_BITS   = ROW_BITS_DEF,
  parameter int unsigned BURST_POS  = BURST_POS_DEF,
  parameter int unsigned BURST_BITS = BURST_BITS_DEF,
  parameter int unsigned AFULL_TH   = 32'd3,
  localparam int unsigned CH_W      = ch_w(NUM_CH),
  localparam int unsigned CNT_W     = cnt_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  bs_multi_queue_if.slave            bus,
  input  logic [NUM_CH-1:0]          flush,
  input  logic                       err_clr,
  output logic [NUM_CH-1:0]          empty,
  output logic [NUM_CH-1:0]          full,
  output logic [NUM_CH-1:0]          afull,
  output logic [NUM_CH*CNT_W-1:0]    count,
  output logic [NUM_CH*ROW_BITS-1:0] head_row,
  output logic [NUM_CH*BURST_BITS-1:0] tail_burst,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam logic [CH_W:0] NUM_CH_C = (CH_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0]     wr_sel_s;
  logic [NUM_CH-1:0]     rd_sel_s;
  logic [NUM_CH-1:0]     wr_drop_s;
  logic [NUM_CH-1:0]     rd_drop_s;
  logic [ENTRY_SIZE-1:0] head_data_s [NUM_CH];
  logic [ENTRY_SIZE-1:0] rd_data_s;
  logic                  wr_ch_ok_s;
  logic                  rd_ch_ok_s;
  logic                  ovf_set_s;
  logic                  udf_set_s;
  logic                  ovf_err_r;
  logic                  udf_err_r;

  // Indices beyond NUM_CH only exist when NUM_CH is not a power of two.
  assign wr_ch_ok_s = ({1'b0, bus.wr_ch} < NUM_CH_C);
  assign rd_ch_ok_s = ({1'b0, bus.rd_ch} < NUM_CH_C);

  genvar gi;
  generate
    for (gi = 0; gi < int'(NUM_CH); gi++) begin : g_ch
      assign wr_sel_s[gi] = bus.wr_en && (bus.wr_ch == CH_W'(gi));
      assign rd_sel_s[gi] = bus.rd_en && (bus.rd_ch == CH_W'(gi));

      bs_queue_ch #(
        .DEPTH      (DEPTH),
        .ENTRY_SIZE (ENTRY_SIZE),
        .ROW_POS    (ROW_POS),
        .ROW_BITS   (ROW_BITS),
        .BURST_POS  (BURST_POS),
        .BURST_BITS (BURST_BITS),
        .AFULL_TH   (AFULL_TH)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush[gi]),
        .wr_req     (wr_sel_s[gi]),
        .wr_data    (bus.wr_data),
        .rd_req     (rd_sel_s[gi]),
        .head_data  (head_data_s[gi]),
        .count      (count[gi*CNT_W +: CNT_W]),
        .empty      (empty[gi]),
        .full       (full[gi]),
        .afull      (afull[gi]),
        .head_row   (head_row[gi*ROW_BITS +: ROW_BITS]),
        .tail_burst (tail_burst[gi*BURST_BITS +: BURST_BITS]),
        .wr_drop    (wr_drop_s[gi]),
        .rd_drop    (rd_drop_s[gi])
      );
    end
  endgenerate

  // Show-ahead read mux; an unmatched index yields zero.
  always_comb begin
    rd_data_s = {ENTRY_SIZE{1'b0}};
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (bus.rd_ch == CH_W'(i)) begin
        rd_data_s = head_data_s[i];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  assign bus.rd_data = rd_data_s;
  assign ovf_set_s   = (|wr_drop_s) || (bus.wr_en && !wr_ch_ok_s);
  assign udf_set_s   = (|rd_drop_s) || (bus.rd_en && !rd_ch_ok_s);

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ovf_err_r <= 1'b0;
      udf_err_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_err_r <= 1'b1;
      end else if (err_clr) begin
        ovf_err_r <= 1'b0;
      end
      if (udf_set_s) begin
        udf_err_r <= 1'b1;
      end else if (err_clr) begin
        udf_err_r <= 1'b0;
      end
    end
  end

  assign ovf_err = ovf_err_r;
  assign udf_err = udf_err_r;

endmodule

// File: tb/tb_bs_multi_queue.sv
// Scoreboard bench for bs_multi_queue: a queue-based reference model predicts
// each cycle's visible state; a separate monitor compares it with the DUT.
module tb_bs_multi_queue;

  typedef struct packed {
    logic [31:0] rd;
    logic [11:0] cnt;
    logic [3:0]  emp;
    logic [3:0]  ful;
    logic [3:0]  af;
    logic [15:0] hr;
    logic [11:0] tb;
    logic        ov;
    logic        ud;
  } snap_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  flush;
  logic        err_clr;
  logic [3:0]  empty;
  logic [3:0]  full;
  logic [3:0]  afull;
  logic [11:0] count;
  logic [15:0] head_row;
  logic [11:0] tail_burst;
  logic        ovf_err;
  logic        udf_err;

  int checks;
  int failures;

  logic [31:0] mq [4][$];
  logic        m_ovf;
  logic        m_udf;
  snap_t       exp_q [$];

  bs_multi_queue_if #(.NUM_CH(4), .ENTRY_SIZE(32)) bus ();

  bs_multi_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .err_clr    (err_clr),
    .empty      (empty),
    .full       (full),
    .afull      (afull),
    .count      (count),
    .head_row   (head_row),
    .tail_burst (tail_burst),
    .ovf_err    (ovf_err),
    .udf_err    (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Visible outputs a correct queue shows for the model's current contents.
  function automatic snap_t model_snap(input logic [1:0] rc);
    snap_t s;
    logic [31:0] e;
    int n;
    s = '0;
    for (int c = 0; c < 4; c++) begin
      n = mq[c].size();
      s.cnt[c*3 +: 3] = 3'(n);
      s.emp[c] = (n == 0);
      s.ful[c] = (n == 4);
      s.af[c]  = (n >= 3);
      if (n > 0) begin
        e = mq[c][0];
        s.hr[c*4 +: 4] = e[19:16];
        e = mq[c][n-1];
        s.tb[c*3 +: 3] = e[22:20];
      end
    end
    if (mq[rc].size() > 0) s.rd = mq[rc][0];
    s.ov = m_ovf;
    s.ud = m_udf;
    return s;
  endfunction

  task automatic model_apply(input logic r, input logic we, input logic [1:0] wc,
                             input logic [31:0] wd, input logic re, input logic [1:0] rc,
                             input logic [3:0] fl, input logic ec);
    logic rd_ok, wr_ok, nov, nud;
    if (r) begin
      for (int c = 0; c < 4; c++) mq[c].delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd_ok = re && !fl[rc] && (mq[rc].size() > 0);
      wr_ok = we && !fl[wc] && ((mq[wc].size() < 4) || (rd_ok && rc == wc));
      nov   = we && !fl[wc] && !wr_ok;
      nud   = re && !fl[rc] && (mq[rc].size() == 0);
      if (rd_ok) void'(mq[rc].pop_front());
      if (wr_ok) mq[wc].push_back(wd);
      for (int c = 0; c < 4; c++) if (fl[c]) mq[c].delete();
      m_ovf = nov ? 1'b1 : (ec ? 1'b0 : m_ovf);
      m_udf = nud ? 1'b1 : (ec ? 1'b0 : m_udf);
    end
  endtask

  // One clock of stimulus: drive, record expectation of the pre-edge state, advance model.
  task automatic step(input logic r, input logic we, input logic [1:0] wc, input logic [31:0] wd,
                      input logic re, input logic [1:0] rc, input logic [3:0] fl, input logic ec);
    @(posedge clk);
    #1;
    rst_n       = r;
    bus.wr_en   = we;
    bus.wr_ch   = wc;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.rd_ch   = rc;
    flush       = fl;
    err_clr     = ec;
    exp_q.push_back(model_snap(rc));
    model_apply(r, we, wc, wd, re, rc, fl, ec);
  endtask

  task automatic wr(input logic [1:0] c, input logic [31:0] d);
    step(1'b0, 1'b1, c, d, 1'b0, c, 4'b0, 1'b0);
  endtask

  task automatic pop(input logic [1:0] c);
    step(1'b0, 1'b0, c, 32'h0, 1'b1, c, 4'b0, 1'b0);
  endtask

  task automatic idle(input logic [1:0] c);
    step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, c, 4'b0, 1'b0);
  endtask

  // Monitor: compare DUT against the oldest expectation each mid-cycle.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("rd_data",    bus.rd_data,        e.rd);
        cmp("count",      {20'h0, count},     {20'h0, e.cnt});
        cmp("empty",      {28'h0, empty},     {28'h0, e.emp});
        cmp("full",       {28'h0, full},      {28'h0, e.ful});
        cmp("afull",      {28'h0, afull},     {28'h0, e.af});
        cmp("head_row",   {16'h0, head_row},  {16'h0, e.hr});
        cmp("tail_burst", {20'h0, tail_burst},{20'h0, e.tb});
        cmp("ovf_err",    {31'h0, ovf_err},   {31'h0, e.ov});
        cmp("udf_err",    {31'h0, udf_err},   {31'h0, e.ud});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] fl;
    int drain;
    checks = 0; failures = 0;
    m_ovf = 1'b0; m_udf = 1'b0;
    rst_n = 1'b1; flush = 4'b0; err_clr = 1'b0;
    bus.wr_en = 1'b0; bus.wr_ch = 2'd0; bus.wr_data = 32'h0;
    bus.rd_en = 1'b0; bus.rd_ch = 2'd0;
    repeat (2) @(posedge clk);

    step(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 4'b0, 1'b0);
    idle(2'd0);
    idle(2'd0);
    cmp("reset_empty", {28'h0, empty}, 32'hF);
    cmp("reset_count", {20'h0, count}, 32'h0);
    cmp("reset_rd",    bus.rd_data,    32'h0);

    wr(2'd2, 32'h0013_0000);
    wr(2'd2, 32'h0025_0000);
    wr(2'd2, 32'h0037_0000);
    idle(2'd2);
    cmp("ch2_count", {29'h0, count[8:6]},      32'd3);
    cmp("ch2_afull", {31'h0, afull[2]},        32'd1);
    cmp("ch2_hrow",  {28'h0, head_row[11:8]},  32'd3);
    cmp("ch2_tburst",{29'h0, tail_burst[8:6]}, 32'd3);
    cmp("ch2_head",  bus.rd_data,              32'h0013_0000);
    pop(2'd2);
    idle(2'd2);
    cmp("ch2_pop_rd",   bus.rd_data,             32'h0025_0000);
    cmp("ch2_pop_hrow", {28'h0, head_row[11:8]}, 32'd5);

    for (int i = 0; i < 5; i++) wr(2'd0, 32'h100 + 32'(i));
    idle(2'd0);
    cmp("ovf_set",  {31'h0, ovf_err}, 32'd1);
    cmp("ch0_full", {31'h0, full[0]}, 32'd1);
    step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 4'b0, 1'b1);
    idle(2'd0);
    cmp("ovf_clr", {31'h0, ovf_err}, 32'd0);

    step(1'b0, 1'b1, 2'd0, 32'hAAAA_AAAA, 1'b1, 2'd0, 4'b0, 1'b0);
    idle(2'd0);
    cmp("full_rw_count", {29'h0, count[2:0]}, 32'd4);
    cmp("full_rw_ovf",   {31'h0, ovf_err},    32'd0);
    repeat (3) pop(2'd0);
    idle(2'd0);
    cmp("full_rw_data", bus.rd_data, 32'hAAAA_AAAA);

    step(1'b0, 1'b1, 2'd1, 32'h0000_0011, 1'b1, 2'd1, 4'b0, 1'b0);
    idle(2'd1);
    cmp("udf_set",   {31'h0, udf_err},    32'd1);
    cmp("udf_count", {29'h0, count[5:3]}, 32'd1);
    cmp("udf_data",  bus.rd_data,         32'h0000_0011);

    step(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 4'b0, 1'b0);
    wr(2'd3, 32'h0031_0000);
    wr(2'd3, 32'h0032_0000);
    wr(2'd0, 32'h0001_0000);
    step(1'b0, 1'b1, 2'd3, 32'h0033_0000, 1'b0, 2'd3, 4'b1000, 1'b0);
    idle(2'd3);
    cmp("flush_count3", {29'h0, count[11:9]}, 32'd0);
    cmp("flush_empty3", {31'h0, empty[3]},    32'd1);
    cmp("flush_count0", {29'h0, count[2:0]},  32'd1);
    cmp("flush_ovf",    {31'h0, ovf_err},     32'd0);
    cmp("flush_udf",    {31'h0, udf_err},     32'd0);

    step(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 4'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      wr(2'd1, (32'(i) << 20) | 32'(i));
      pop(2'd1);
    end
    idle(2'd1);

    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 4; c++) fl[c] = ($urandom_range(0, 31) == 0);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
           $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), fl,
           ($urandom_range(0, 15) == 0));
    end
    idle(2'd0);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bs_multi_queue.md
Name: bs_multi_queue

Overview:
- Parametrised successor to the single bank-scheduler array: NUM_CH independent circular queues share one write port and one read port.
- Sits between the request classifier and the bank scheduler. Each channel is one bank/group queue.
- Per channel it exposes show-ahead head data, head row field, tail burst field, occupancy, empty/full/almost-full.
- Adds over the previous generation: channel count, per-channel flush, almost-full threshold, and protected overflow/underflow with sticky error flags.

Parameters:
- NUM_CH, 4, number of independent queues (>=2).
- DEPTH, 4, entries per queue; power of two, >=2.
- ENTRY_SIZE, 32, entry width in bits.
- ROW_POS, 16, LSB of row field inside an entry.
- ROW_BITS, 4, row field width.
- BURST_POS, 20, LSB of burst field inside an entry.
- BURST_BITS, 3, burst field width.
- AFULL_TH, 3, afull asserts when count >= AFULL_TH; range 1..DEPTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-high. Name kept from codebase; polarity is high.
- wr_en  in  1  write request.
- wr_ch  in  CH_W=$clog2(NUM_CH)  target channel of write.
- wr_data  in  ENTRY_SIZE  entry to enqueue.
- rd_en  in  1  pop request.
- rd_ch  in  CH_W  channel to pop / channel driven on rd_data.
- rd_data  out  ENTRY_SIZE  show-ahead head of rd_ch; 0 when that channel is empty.
- flush  in  NUM_CH  per-channel discard-all mask.
- err_clr  in  1  clears sticky error flags.
- empty  out  NUM_CH  count==0 per channel.
- full  out  NUM_CH  count==DEPTH per channel.
- afull  out  NUM_CH  count>=AFULL_TH per channel.
- count  out  NUM_CH*(CNT_W=$clog2(DEPTH)+1)  occupancy; channel i at [i*CNT_W +: CNT_W].
- head_row  out  NUM_CH*ROW_BITS  row field of head entry; 0 if empty.
- tail_burst  out  NUM_CH*BURST_BITS  burst field of most recently written entry; 0 if empty.
- ovf_err  out  1  sticky: write to a full channel was dropped.
- udf_err  out  1  sticky: read of an empty channel was ignored.

Behaviour:
- Reset (rst_n=1 at edge):
  - All pointers, counts and storage clear to 0.
  - empty=all 1; full=afull=0; rd_data=head_row=tail_burst=0; ovf_err=udf_err=0.
  - Reset overrides every other input in the same cycle. Reset mid-operation discards all contents.
- Storage:
  - Per channel: rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping naturally DEPTH-1 -> 0.
  - Per channel count is CNT_W bits.
- Write, wr_en=1 on channel c:
  - Accepted if count[c]<DEPTH, or if count[c]==DEPTH and the same cycle also has an accepted read on c.
  - Accepted write: entry stored at wr_ptr[c], wr_ptr[c]+1.
  - Otherwise the write is dropped, no state change, ovf_err<=1.
- Read, rd_en=1 on channel c:
  - Accepted if count[c]>0 at the start of the cycle; rd_ptr[c]+1.
  - On an empty channel the read is ignored and udf_err<=1, even if a write to c lands in the same cycle.
- Count update: +1 on write only, -1 on read only, unchanged on both.
- Reads and writes to different channels in the same cycle are independent.
- Latency:
  - Combinational show-ahead. rd_data, head_row, tail_burst, flags and count reflect state after the last edge.
  - A written entry is visible on rd_data the cycle after the write.
- Tail: tail_burst uses entry at wr_ptr-1, with wr_ptr==0 mapping to index DEPTH-1.
- Flush:
  - flush[c]=1 sets rd_ptr[c]=wr_ptr[c]=count[c]=0 next cycle.
  - Flush wins over a same-cycle read or write on c: both are ignored and raise no error.
  - Other channels are unaffected.
- err_clr: clears both sticky flags. If an error occurs in the same cycle, the new error wins and the flag stays 1.
- Out-of-range channel index (wr_ch or rd_ch >= NUM_CH, non-power-of-two NUM_CH):
  - The request is ignored.
  - Write sets ovf_err; read sets udf_err.
  - rd_data=0.
- No state machine beyond per-channel pointer/counter registers. Entries are not cleared on read.

Decomposition:
- Package bs_queue_pkg holds:
  - functions for CH_W and CNT_W;
  - the localparam defaults for ROW_POS/BURST_POS field layout, shared with the classifier and scheduler.
- One sub-module, bs_queue_ch: a single-channel queue with accept/flush/count logic and head/tail field extraction.
- bs_multi_queue instantiates NUM_CH copies via generate, decodes wr_ch/rd_ch, muxes rd_data, and owns the sticky flags.

Test Plan:
- Reset, then idle -> empty=4'b1111, count all 0, rd_data=0, ovf_err=udf_err=0.
- Write 0x0013_0000, 0x0025_0000, 0x0037_0000 to ch2 (ROW_POS=16 gives row fields 3/5/7; BURST_POS=20 gives burst fields 1/2/3):
  - count[ch2]=3, afull[2]=1, head_row[ch2]=3, tail_burst[ch2]=3.
  - Pop, rd_ch=2 -> rd_data=0x0025_0000, head_row=5.
- Fill ch0 with 4 entries, then a 5th write -> dropped, ovf_err=1, full[0]=1. Then err_clr -> ovf_err=0.
- ch0 full, same cycle rd_en/wr_en on ch0 with wr_data=0xAAAA_AAAA -> count stays 4, no ovf_err. After 3 more pops, rd_data=0xAAAA_AAAA.
- ch1 empty, rd_en on ch1 with simultaneous wr_en on ch1 -> udf_err=1, count[1]=1, entry retained.
- Load ch3 with 2 entries and ch0 with 1, then assert flush=4'b1000 with a write to ch3 in the same cycle -> count[3]=0, empty[3]=1, count[0]=1, no error flags.
- Wrap-around: 10 interleaved write/pop pairs on ch1 with data 1..10 -> in-order data, tail_burst correct when wr_ptr wraps to 0.
